alu_rr_arbiter: RTL

Round-robin arbiter and sequencer that shares one combinational 32-bit ALU among `2**ID_W` requesters. Each requester presents an operation over a valid/ready handshake. The arbiter grants one request at a time, drives the ALU from registered operands, captures the ALU result and flags, and returns them with the requester ID over a backpressured response channel. It sits between the issuing units and the single `alu` instance. The ALU's own `rst_n` is tied to the system `rst_n` outside this block.

---
 rtl/alu_rr_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter that shares one combinational ALU among 2**ID_W requesters.
// One operation is in flight at a time: accept in IDLE, capture in EXEC, hand back in RESP.
module alu_rr_arbiter #(
    parameter int ID_W = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2**ID_W-1:0]      req_valid,
    output logic [2**ID_W-1:0]      req_ready,
    input  logic [32*(2**ID_W)-1:0] req_src1,
    input  logic [32*(2**ID_W)-1:0] req_src2,
    input  logic [4*(2**ID_W)-1:0]  req_ctrl,
    input  logic [3*(2**ID_W)-1:0]  req_bonus,
    output logic [31:0]             alu_src1,
    output logic [31:0]             alu_src2,
    output logic [3:0]              alu_ctrl,
    output logic [2:0]              alu_bonus,
    input  logic [31:0]             alu_result,
    input  logic                    alu_zero,
    input  logic                    alu_cout,
    input  logic                    alu_overflow,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_result,
    output logic                    rsp_zero,
    output logic                    rsp_cout,
    output logic                    rsp_overflow,
    output logic                    rsp_err,
    output logic                    busy
);
    localparam int N      = 2**ID_W;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] cur_id;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            accept;

    function automatic logic opcode_legal(input logic [3:0] ctrl);
        case (ctrl)
            4'b0000, 4'b0001, 4'b0010, 4'b0110,
            4'b0111, 4'b1100, 4'b1101: opcode_legal = 1'b1;
            default:                   opcode_legal = 1'b0;
        endcase
    endfunction

    // Search starts one past the last grant; the ID_W-bit sum wraps modulo N for free.
    always_comb begin
        logic [ID_W-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = last_grant;
        cand        = '0;
        for (int k = 1; k <= N; k++) begin
            cand = last_grant + ID_W'(k);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept    = rst_n && (state == IDLE) && grant_found;
    assign req_ready = accept ? (N'(1) << grant_idx) : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= '1;
            cur_id       <= '0;
            alu_src1     <= '0;
            alu_src2     <= '0;
            alu_ctrl     <= '0;
            alu_bonus    <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_cout     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_src1   <= req_src1[grant_idx*DATA_W +: DATA_W];
                        alu_src2   <= req_src2[grant_idx*DATA_W +: DATA_W];
                        alu_ctrl   <= req_ctrl[grant_idx*4 +: 4];
                        alu_bonus  <= req_bonus[grant_idx*3 +: 3];
                        cur_id     <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= cur_id;
                    // An unsupported opcode returns a clean zero result flagged as an error.
                    if (opcode_legal(alu_ctrl)) begin
                        rsp_result   <= alu_result;
                        rsp_zero     <= alu_zero;
                        rsp_cout     <= alu_cout;
                        rsp_overflow <= alu_overflow;
                        rsp_err      <= 1'b0;
                    end else begin
                        rsp_result   <= '0;
                        rsp_zero     <= 1'b0;
                        rsp_cout     <= 1'b0;
                        rsp_overflow <= 1'b0;
                        rsp_err      <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
